fifo_rd_fwft: RTL and testbench
===============================

Name: fifo_rd_fwft

Overview:
- Read-side output stage of the async FIFO, in the rclk domain, directly downstream of the read-pointer/empty logic and the FIFO memory.
- Consumes rempty and the combinational memory read data at the current raddr, and drives rinc back to the pointer logic.
- Presents a registered first-word-fall-through valid/ready stream through a 2-entry output buffer (output register plus skid register).
- Sustains 1 word/cycle with no combinational path from m_ready to rinc.

Parameters:
DSIZE, 8, data word width in bits

Ports:
rclk  input  1  read-domain clock
rrst_n  input  1  read-domain reset; asynchronous assert, active-low, same reset as the read-pointer logic
rempty  input  1  registered FIFO empty flag from the read-pointer logic
rdata  input  DSIZE  memory read data at the current raddr; valid whenever rempty=0
rinc  output  1  pop request to the read-pointer logic
m_valid  output  1  output word valid
m_ready  input  1  downstream accepts the word
m_data  output  DSIZE  output word
level  output  2  words held in this stage (0..2)

Behaviour:
- Reset (rrst_n=0, async): m_valid=0, m_data=0, skid_valid=0, skid_data=0, level=0, rinc=0. Buffered words are discarded.
- Definitions: pop = m_valid & m_ready; fetch = rinc.
- rinc = ~rempty & ~skid_valid. It is combinational from registered state only and never depends on m_ready.
- Every rising rclk edge applies exactly one case, in this priority:
  - A, fetch & (~m_valid | pop): m_data<=rdata; m_valid<=1. skid is unchanged and empty.
  - B, fetch & m_valid & ~pop: skid_data<=rdata; skid_valid<=1. m_data/m_valid are held.
  - C, ~fetch & pop & skid_valid: m_data<=skid_data; m_valid<=1; skid_valid<=0.
  - D, ~fetch & pop & ~skid_valid: m_valid<=0. m_data keeps its last value.
  - Otherwise: hold all state.
- fetch & skid_valid is impossible by construction. Flag a simulation assertion if it occurs.
- level = m_valid + skid_valid. It is combinational from registers.
- Invariant: skid_valid implies m_valid. level never exceeds 2.
- Latency: a word written into an empty FIFO appears on m_valid one rclk after rempty deasserts.
- Full throughput: at level 1 with m_ready held high and rempty=0, case A repeats every cycle, giving one word per cycle with level staying 1.
- Backpressure:
  - m_ready=0 with m_valid=1 holds m_data/m_valid stable until accepted (AXI-stream rules).
  - At most one further word is absorbed into skid, then rinc drops.
- Ordering: words leave strictly in FIFO order. The skid word always follows the m_data word.
- Empty boundary: rempty=1 forces rinc=0 regardless of buffer state. rdata is ignored while rempty=1.
- Simultaneous pop and skid refill (case C) is the only transfer from skid. It never coincides with a FIFO fetch.
- Mid-operation reset: all outputs return to reset values immediately and asynchronously. The read pointer resets on the same rrst_n, so no pop is lost or duplicated relative to the pointer.

Test Plan:
- Reset then idle with rempty=1 -> m_valid=0, rinc=0, level=0 every cycle; m_data=0.
- Write 0xA5 into an empty FIFO (rempty falls at cycle t), m_ready=1 -> rinc=1 at t; m_valid=1 with m_data=0xA5 at t+1; m_valid=0 at t+2; exactly one rinc pulse.
- Stream 16 words 0x00..0x0F with m_ready=1 constantly -> 16 consecutive m_valid cycles, data in order, rinc high 16 cycles, level=1 throughout streaming.
- m_ready=0 with 4 words queued -> level reaches 2 after 2 cycles, then rinc=0 and m_data=0x00 held. Raise m_ready -> outputs 0x00,0x01,0x02,0x03 on consecutive cycles with no gap and no duplicate.
- Random m_ready (50%) and random write bursts for 2000 words -> scoreboard order/data match, level<=2, skid_valid implies m_valid, no fetch while skid_valid.
- Assert rrst_n=0 mid-stream at level=2 -> m_valid, level, rinc go to 0 immediately. After release with an empty FIFO, no stale word appears.

Source files
------------

// File: rtl/fifo_rd_fwft_if.sv
// Purpose: valid/ready word stream leaving the FIFO read-side output stage.
//   valid : word on data is valid (driven by the master)
//   ready : sink accepts the word this cycle (driven by the slave)
//   data  : word payload, DSIZE bits (driven by the master)
// A word transfers on a clock edge where valid and ready are both high.
interface fifo_rd_fwft_if #(
  parameter int DSIZE = 8
);
  logic             valid;
  logic             ready;
  logic [DSIZE-1:0] data;

  modport master (
    output valid,
    output data,
    input  ready
  );

  modport slave (
    input  valid,
    input  data,
    output ready
  );
endinterface

// File: rtl/fifo_rd_fwft.sv
// Purpose: read-side first-word-fall-through output stage of the async FIFO,
// running in the rclk domain. It pulls words out of the FIFO memory via rinc
// and presents them on a registered valid/ready stream through a two-entry
// buffer (output register plus skid register). It sustains one word per
// cycle, and m.ready never reaches rinc combinationally.
// Ports:
//   rclk   : read-domain clock
//   rrst_n : asynchronous active-low reset, shared with the read-pointer logic
//   rempty : registered empty flag from the read-pointer logic
//   rdata  : memory read data at the current read address (valid when !rempty)
//   rinc   : pop request back to the read-pointer logic
//   m      : output stream (master side): valid, data out; ready in
//   level  : number of words held in this stage (0..2)
module fifo_rd_fwft #(
  parameter int DSIZE = 8
) (
  input  logic             rclk,
  input  logic             rrst_n,
  input  logic             rempty,
  input  logic [DSIZE-1:0] rdata,
  output logic             rinc,
  fifo_rd_fwft_if.master   m,
  output logic [1:0]       level
);

  logic             m_valid_q;
  logic [DSIZE-1:0] m_data_q;
  logic             skid_valid_q;
  logic [DSIZE-1:0] skid_data_q;

  logic             m_valid_d;
  logic [DSIZE-1:0] m_data_d;
  logic             skid_valid_d;
  logic [DSIZE-1:0] skid_data_d;

  logic             pop;
  logic             fetch;

  // The FIFO is only popped while the skid register is free, so any word
  // fetched this cycle always has somewhere to land even if the consumer
  // stalls. Only registered state is used, keeping m.ready off this path.
  assign rinc  = ~rempty & ~skid_valid_q;
  assign fetch = rinc;
  assign pop   = m_valid_q & m.ready;

  // Next-state selection. Priority order matters: a fetch either refills the
  // output register (when it is empty or being drained) or parks in skid;
  // without a fetch, a pop promotes the skid word or empties the stage.
  always_comb begin
    m_valid_d    = m_valid_q;
    m_data_d     = m_data_q;
    skid_valid_d = skid_valid_q;
    skid_data_d  = skid_data_q;
    if (fetch && (!m_valid_q || pop)) begin
      m_data_d  = rdata;
      m_valid_d = 1'b1;
    end else if (fetch) begin
      skid_data_d  = rdata;
      skid_valid_d = 1'b1;
    end else if (pop && skid_valid_q) begin
      m_data_d     = skid_data_q;
      m_valid_d    = 1'b1;
      skid_valid_d = 1'b0;
    end else if (pop) begin
      // m_data keeps the word just accepted; only valid drops.
      m_valid_d = 1'b0;
    end
  end

  always_ff @(posedge rclk or negedge rrst_n) begin
    if (!rrst_n) begin
      m_valid_q    <= 1'b0;
      m_data_q     <= '0;
      skid_valid_q <= 1'b0;
      skid_data_q  <= '0;
    end else begin
      m_valid_q    <= m_valid_d;
      m_data_q     <= m_data_d;
      skid_valid_q <= skid_valid_d;
      skid_data_q  <= skid_data_d;
    end
  end

  assign m.valid = m_valid_q;
  assign m.data  = m_data_q;
  assign level   = {1'b0, m_valid_q} + {1'b0, skid_valid_q};

  // A fetch while the skid register is occupied would overwrite a word, and
  // a skid word without an output word would break ordering.
  assert property (@(posedge rclk) disable iff (!rrst_n) !(fetch && skid_valid_q))
    else $error("fifo_rd_fwft: fetch while skid register occupied");
  assert property (@(posedge rclk) disable iff (!rrst_n) !(skid_valid_q && !m_valid_q))
    else $error("fifo_rd_fwft: skid word held without an output word");

endmodule

// File: tb/tb_fifo_rd_fwft.sv
// Purpose: self-checking bench for fifo_rd_fwft. The upstream FIFO is a plain
// queue; the output stage is modelled as a queue of at most two words that
// pops its head on an accepted transfer and appends the FIFO head whenever
// the FIFO is non-empty and fewer than two words are held.
module tb_fifo_rd_fwft;
  localparam int DSIZE = 8;

  logic             rclk;
  logic             rrst_n;
  logic             rempty;
  logic [DSIZE-1:0] rdata;
  logic             rinc;
  logic [1:0]       level;

  fifo_rd_fwft_if #(.DSIZE(DSIZE)) bus ();

  fifo_rd_fwft #(.DSIZE(DSIZE)) dut (
    .rclk   (rclk),
    .rrst_n (rrst_n),
    .rempty (rempty),
    .rdata  (rdata),
    .rinc   (rinc),
    .m      (bus.master),
    .level  (level)
  );

  initial rclk = 1'b0;
  always #5 rclk = ~rclk;

  int n_checks = 0;
  int n_pass   = 0;

  // Reference model state.
  logic [DSIZE-1:0] fifo_q[$];
  logic [DSIZE-1:0] buf_q[$];
  logic [DSIZE-1:0] sb_q[$];
  logic [DSIZE-1:0] last_data;

  // Values sampled in the most recent cycle, for hand-computed checks.
  logic             s_rinc;
  logic             s_valid;
  logic [DSIZE-1:0] s_data;
  logic [1:0]       s_level;

  task automatic check_output(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
  endtask

  task automatic push_word(input logic [DSIZE-1:0] w);
    fifo_q.push_back(w);
    sb_q.push_back(w);
  endtask

  // One rclk cycle: drive inputs, compare all outputs to the model, then
  // advance the model across the rising edge.
  task automatic apply_stimulus(input logic rdy);
    logic             exp_rinc;
    logic             exp_pop;
    logic [DSIZE-1:0] exp_data;
    logic [DSIZE-1:0] word;
    @(negedge rclk);
    bus.ready = rdy;
    rempty    = (fifo_q.size() == 0);
    rdata     = rempty ? DSIZE'($urandom) : fifo_q[0];
    #1;
    exp_rinc = !rempty && (buf_q.size() < 2);
    exp_pop  = (buf_q.size() != 0) && rdy;
    exp_data = (buf_q.size() != 0) ? buf_q[0] : last_data;
    s_rinc  = rinc;
    s_valid = bus.valid;
    s_data  = bus.data;
    s_level = level;
    check_output("rinc",    32'(rinc),      32'(exp_rinc));
    check_output("m_valid", 32'(bus.valid), 32'(buf_q.size() != 0));
    check_output("m_data",  32'(bus.data),  32'(exp_data));
    check_output("level",   32'(level),     32'(buf_q.size()));
    if (exp_pop) begin
      if (sb_q.size() == 0) check_output("order_underflow", 32'(1), 32'(0));
      else check_output("order", 32'(bus.data), 32'(sb_q.pop_front()));
    end
    @(posedge rclk);
    if (exp_pop) begin
      word = buf_q.pop_front();
      last_data = word;
    end
    if (exp_rinc) buf_q.push_back(fifo_q.pop_front());
    if (buf_q.size() != 0) last_data = buf_q[0];
  endtask

  task automatic model_reset();
    fifo_q.delete();
    buf_q.delete();
    sb_q.delete();
    last_data = '0;
  endtask

  initial begin
    int written;
    int cyc;
    int n;

    // Reset with the pointer logic also held empty.
    rrst_n    = 1'b0;
    rempty    = 1'b1;
    rdata     = '0;
    bus.ready = 1'b0;
    model_reset();
    #1;
    check_output("reset_m_valid", 32'(bus.valid), 32'(0));
    check_output("reset_m_data",  32'(bus.data),  32'(0));
    check_output("reset_level",   32'(level),     32'(0));
    check_output("reset_rinc",    32'(rinc),      32'(0));
    repeat (3) @(posedge rclk);
    @(negedge rclk);
    rrst_n = 1'b1;

    // Idle with an empty FIFO.
    repeat (4) apply_stimulus(1'b1);
    check_output("idle_data_lit", 32'(s_data), 32'(0));

    // Single word 0xA5 into an empty FIFO.
    push_word(8'hA5);
    apply_stimulus(1'b1);
    check_output("a5_t_rinc",   32'(s_rinc),  32'(1));
    check_output("a5_t_valid",  32'(s_valid), 32'(0));
    apply_stimulus(1'b1);
    check_output("a5_t1_valid", 32'(s_valid), 32'(1));
    check_output("a5_t1_data",  32'(s_data),  32'(8'hA5));
    check_output("a5_t1_rinc",  32'(s_rinc),  32'(0));
    apply_stimulus(1'b1);
    check_output("a5_t2_valid", 32'(s_valid), 32'(0));
    check_output("a5_t2_rinc",  32'(s_rinc),  32'(0));

    // Stream 16 words with the consumer always ready.
    for (int i = 0; i < 16; i++) push_word(DSIZE'(i));
    apply_stimulus(1'b1);
    check_output("stream_first_rinc", 32'(s_rinc), 32'(1));
    for (int k = 1; k <= 16; k++) begin
      apply_stimulus(1'b1);
      check_output("stream_valid", 32'(s_valid), 32'(1));
      check_output("stream_data",  32'(s_data),  32'(k - 1));
      check_output("stream_level", 32'(s_level), 32'(1));
      check_output("stream_rinc",  32'(s_rinc),  32'(k < 16));
    end
    repeat (3) apply_stimulus(1'b1);

    // Backpressure with four queued words.
    for (int i = 0; i < 4; i++) push_word(DSIZE'(i));
    repeat (3) apply_stimulus(1'b0);
    check_output("bp_level", 32'(s_level), 32'(2));
    check_output("bp_rinc",  32'(s_rinc),  32'(0));
    check_output("bp_data",  32'(s_data),  32'(0));
    apply_stimulus(1'b0);
    check_output("bp_hold_data", 32'(s_data), 32'(0));
    for (int k = 0; k < 4; k++) begin
      apply_stimulus(1'b1);
      check_output("bp_drain_valid", 32'(s_valid), 32'(1));
      check_output("bp_drain_data",  32'(s_data),  32'(k));
    end
    apply_stimulus(1'b1);
    check_output("bp_done_valid", 32'(s_valid), 32'(0));

    // Randomised writes and consumer readiness.
    written = 0;
    cyc = 0;
    while ((written < 2000 || fifo_q.size() != 0 || buf_q.size() != 0) && cyc < 20000) begin
      if (written < 2000 && $urandom_range(0, 3) == 0) begin
        n = $urandom_range(1, 6);
        for (int j = 0; j < n && written < 2000; j++) begin
          push_word(DSIZE'($urandom));
          written++;
        end
      end
      apply_stimulus(1'($urandom_range(0, 1)));
      cyc++;
    end
    check_output("random_no_timeout", 32'(cyc < 20000), 32'(1));
    check_output("random_sb_empty",   32'(sb_q.size()), 32'(0));

    // Reset in the middle of a stream with the buffer full.
    for (int i = 0; i < 4; i++) push_word(DSIZE'(8'h40 + i));
    repeat (3) apply_stimulus(1'b0);
    check_output("mid_level_full", 32'(s_level), 32'(2));
    @(negedge rclk);
    rrst_n = 1'b0;
    rempty = 1'b1;
    #1;
    check_output("mid_rst_valid", 32'(bus.valid), 32'(0));
    check_output("mid_rst_level", 32'(level),     32'(0));
    check_output("mid_rst_rinc",  32'(rinc),      32'(0));
    check_output("mid_rst_data",  32'(bus.data),  32'(0));
    model_reset();
    repeat (2) @(posedge rclk);
    @(negedge rclk);
    rrst_n = 1'b1;
    for (int k = 0; k < 5; k++) begin
      apply_stimulus(1'b1);
      check_output("post_rst_valid", 32'(s_valid), 32'(0));
    end

    $display("[TB] %0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
